// File: rtl/rr_slot_arbiter.sv
// rtl/rr_slot_arbiter.sv - four-requester round-robin arbiter with bounded hold and turnaround cycle
// Grants one owner at a time; the owner loses priority on release and the grant is revoked after MAX_HOLD cycles.
module rr_slot_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       rel,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [3:0]          gnt_q, gnt_d;
   logic [1:0]          gnt_id_q, gnt_id_d;
   logic                busy_q, busy_d;
   logic                timeout_q, timeout_d;

   logic [1:0]          win;
   logic [1:0]          cand;
   logic                found;
   logic                owner_req;
   logic                hold_done;

   // Search starts at ptr and wraps, so the last owner is checked last.
   always_comb begin
      win   = 2'd0;
      cand  = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign owner_req = req[gnt_id_q];
   assign hold_done = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
            busy_d   = 1'b0;
            if (found) begin
               gnt_d      = 4'b0001 << win;
               gnt_id_d   = win;
               busy_d     = 1'b1;
               hold_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (rel || !owner_req || hold_done) begin
               gnt_d     = 4'b0000;
               gnt_id_d  = 2'd0;
               busy_d    = 1'b0;
               ptr_d     = gnt_id_q + 2'd1;
               // A forced release is only flagged when the owner did not also let go.
               timeout_d = hold_done && !rel && owner_req;
               state_d   = RECOVER;
            end
         end
         RECOVER: begin
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            gnt_d    = 4'b0000;
            gnt_id_d = 2'd0;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 2'd0;
         hold_cnt_q <= '0;
         gnt_q      <= 4'b0000;
         gnt_id_q   <= 2'd0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// tb/tb_rr_slot_arbiter.sv - directed vector bench for rr_slot_arbiter
module tb_rr_slot_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       rel;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;

   int pass_cnt = 0;
   int total_cnt = 0;

   rr_slot_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .rel     (rel),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       rel;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       tmo;
   } vec_t;

   vec_t tbl[30];

   function automatic vec_t mk(input logic [3:0] r, input logic l, input logic [3:0] g,
                               input logic [1:0] i, input logic b, input logic t);
      vec_t v;
      v.req = r; v.rel = l; v.gnt = g; v.id = i; v.busy = b; v.tmo = t;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got {gnt,id,busy,tmo}=%b required %b", nm, act, exp);
   endtask

   // Called at a negedge: drive inputs, let one rising edge pass, check on the next negedge.
   task automatic step(input string nm, input logic [3:0] r, input logic l,
                       input logic [3:0] g, input logic [1:0] i, input logic b, input logic t);
      req = r;
      rel = l;
      @(posedge clk);
      @(negedge clk);
      chk(nm, {gnt, gnt_id, busy, timeout}, {g, i, b, t});
   endtask

   initial begin
      // rotation with rel pulsed, ptr starting at 0
      tbl[0]  = mk(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      tbl[1]  = mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      tbl[2]  = mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0);
      tbl[3]  = mk(4'b1111, 0, 4'b0010, 2'd1, 1, 0);
      tbl[4]  = mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      tbl[5]  = mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0);
      tbl[6]  = mk(4'b1111, 0, 4'b0100, 2'd2, 1, 0);
      tbl[7]  = mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      tbl[8]  = mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0);
      tbl[9]  = mk(4'b1111, 0, 4'b1000, 2'd3, 1, 0);
      tbl[10] = mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      tbl[11] = mk(4'b1111, 0, 4'b0000, 2'd0, 0, 0);
      tbl[12] = mk(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      tbl[13] = mk(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      tbl[14] = mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      // ptr=1: grant 2, then ptr=3 with req 0101 -> 0, then 2
      tbl[15] = mk(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      tbl[16] = mk(4'b0101, 1, 4'b0000, 2'd0, 0, 0);
      tbl[17] = mk(4'b0101, 0, 4'b0000, 2'd0, 0, 0);
      tbl[18] = mk(4'b0101, 0, 4'b0001, 2'd0, 1, 0);
      tbl[19] = mk(4'b0101, 1, 4'b0000, 2'd0, 0, 0);
      tbl[20] = mk(4'b0101, 0, 4'b0000, 2'd0, 0, 0);
      tbl[21] = mk(4'b0101, 0, 4'b0100, 2'd2, 1, 0);
      tbl[22] = mk(4'b0101, 1, 4'b0000, 2'd0, 0, 0);
      tbl[23] = mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      tbl[24] = mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      // ptr=3: grant 1, then withdrawal releases on the next edge
      tbl[25] = mk(4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      tbl[26] = mk(4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      tbl[27] = mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      tbl[28] = mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      tbl[29] = mk(4'b0000, 0, 4'b0000, 2'd0, 0, 0);

      rst = 1'b1;
      req = 4'b0000;
      rel = 1'b0;
      @(negedge clk);
      chk("reset_values", {gnt, gnt_id, busy, timeout}, 8'b0);
      rst = 1'b0;

      for (int k = 0; k < 30; k++)
         step($sformatf("vec%0d", k), tbl[k].req, tbl[k].rel, tbl[k].gnt, tbl[k].id,
              tbl[k].busy, tbl[k].tmo);

      // timeout: ptr=2, owner 2 holds for exactly 8 cycles
      for (int k = 0; k < 8; k++)
         step($sformatf("hold%0d", k), 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("timeout_pulse", 4'b0100, 0, 4'b0000, 2'd0, 0, 1);
      step("timeout_clear", 4'b0100, 0, 4'b0000, 2'd0, 0, 0);
      step("regrant_after_tmo", 4'b0100, 0, 4'b0100, 2'd2, 1, 0);

      // rel coincides with the final hold cycle: no timeout pulse
      for (int k = 1; k < 8; k++)
         step($sformatf("hold2_%0d", k), 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
      step("rel_at_limit", 4'b0100, 1, 4'b0000, 2'd0, 0, 0);
      step("rel_at_limit_gap", 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      step("rel_at_limit_idle", 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

      // long idle, ptr stays 3
      for (int k = 0; k < 20; k++)
         step($sformatf("idle%0d", k), 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      step("idle_then_grant3", 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
      step("rel3", 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
      step("rel3_gap", 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

      // ptr=0: grant 1, release (ptr=2), grant 1 again, then reset mid-grant
      step("pre_rst_grant", 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      step("pre_rst_rel", 4'b0010, 1, 4'b0000, 2'd0, 0, 0);
      step("pre_rst_gap", 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
      step("pre_rst_grant2", 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
      #2 rst = 1'b1;
      #1 chk("async_reset_drop", {gnt, gnt_id, busy, timeout}, 8'b0);
      @(negedge clk);
      chk("reset_held", {gnt, gnt_id, busy, timeout}, 8'b0);
      rst = 1'b0;
      step("post_rst_ptr0", 4'b0110, 0, 4'b0010, 2'd1, 1, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Four-requester round-robin arbiter that shares one resource (e.g. a counter datapath or bus slot) among requesters 0-3.
- A 2-bit priority pointer advances and wraps 3->0 after each grant.
- A hold counter bounds how long any owner may keep the grant.
- Sits between the requesting blocks and the shared resource. Drives the one-hot grant and the owner ID used to mux the resource.

Parameters:
- MAX_HOLD, 8, maximum cycles one owner may hold the grant before forced release; legal range 1-15.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester request, level-sensitive.
- rel  in  1  current owner releases the resource; sampled only in GRANT.
- gnt  out  4  one-hot grant; all-zero when no owner.
- gnt_id  out  2  binary index of current owner; 0 when gnt is zero.
- busy  out  1  high while state is GRANT.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE, ptr=0, hold_cnt=0, gnt=4'b0000, gnt_id=0, busy=0, timeout=0.
- Reset asserted mid-grant drops gnt immediately (asynchronously). No timeout pulse is produced.

State machine, states IDLE, GRANT, RECOVER:
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, select winner = first set bit of req, searching ptr, ptr+1, ... modulo 4.
  - Next edge: gnt=one-hot(winner), gnt_id=winner, busy=1, hold_cnt=0, go to GRANT.
  - Latency: request sampled at edge k -> gnt visible after edge k, i.e. one cycle.
- GRANT:
  - hold_cnt increments each cycle.
  - Release conditions, evaluated each edge:
    - (a) rel=1;
    - (b) req[gnt_id]=0 (requester withdrew);
    - (c) hold_cnt==MAX_HOLD-1 (grant held for MAX_HOLD cycles).
  - On any of these: gnt=0, gnt_id=0, busy=0, ptr=(gnt_id+1) mod 4 (wraps 3->0), go to RECOVER.
  - timeout=1 for one cycle only when (c) is the sole cause. If rel or withdrawal coincides with (c), timeout stays 0.
- RECOVER:
  - One dead cycle with gnt=0 (turnaround guarantee). Go to IDLE unconditionally.
  - Minimum gap between consecutive grants is therefore 2 cycles of gnt=0: RECOVER plus the IDLE decision cycle.
- Other rules:
  - Requests arriving in GRANT or RECOVER are not lost; they are seen in IDLE if still asserted.
  - ptr changes only on release. It never changes in IDLE without a grant.
  - The requester holding the grant gets lowest priority at the next arbitration. A single continuous requester is re-granted after the 2-cycle gap.
  - Invariant: gnt is always one-hot or zero, and gnt_id matches gnt.
  - Unreachable state encodings return to IDLE with outputs zero.

Test Plan:
- Reset: assert rst mid-GRANT with req=4'b0010 -> gnt, busy, timeout drop to 0 without waiting for clk; after release, first grant goes to requester 1 (ptr=0, search 0,1).
- Rotation: req=4'b1111 held, rel pulsed 1 cycle after each grant -> gnt sequence 0001, 0010, 0100, 1000, 0001, with 2 zero cycles between each.
- Pointer skip and wrap: ptr=3 after owner 2; req=4'b0101 -> grant 0 (search 3,0); next arbitration grants 2.
- Timeout: MAX_HOLD=8, req=4'b0100 held, rel=0 -> gnt=0100 for exactly 8 cycles, then gnt=0 and timeout=1 for 1 cycle, ptr=3; re-grant to 2 two cycles later.
- Simultaneous: rel=1 on the same edge hold_cnt reaches 7 -> release with timeout=0. Separately, req[owner] dropped mid-grant -> release on the next edge.
- Idle: req=0 for 20 cycles -> gnt=0, busy=0, ptr unchanged; then req=4'b1000 -> gnt=1000, gnt_id=3 after 1 edge.
